// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with modulus, wrap/saturate limit handling,
// parallel load, synchronous clear, terminal-count and overflow flags.
module counter_updown_mod #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULUS  = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] ctr,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam int unsigned   CW  = WIDTH + 1;
  localparam logic [CW-1:0] TOP = CW'(MODULUS - 1);

  logic [CW-1:0]    cur;
  logic [CW-1:0]    ld_ext;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ld_clamp;
  logic             at_top;
  logic             at_bot;
  logic             limit;

  assign cur    = {1'b0, ctr};
  assign ld_ext = {1'b0, load_val};

  // Next count, limit detection and load clamping, all in WIDTH+1 bits
  always_comb begin
    at_top   = (cur == TOP);
    at_bot   = (cur == '0);
    limit    = en & (up_dn ? at_top : at_bot);
    nxt      = ctr;
    ld_clamp = load_val;
    if (up_dn) begin
      if (at_top) nxt = (SATURATE != 0) ? WIDTH'(TOP) : '0;
      else        nxt = WIDTH'(cur + CW'(1));
    end else begin
      if (at_bot) nxt = (SATURATE != 0) ? '0 : WIDTH'(TOP);
      else        nxt = WIDTH'(cur - CW'(1));
    end
    if (ld_ext > TOP) ld_clamp = WIDTH'(TOP);
  end

  assign tc = limit;

  // Priority: reset, clear, load, count, hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctr  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr) begin
      ctr  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      ctr  <= ld_clamp;
      wrap <= 1'b0;
    end else if (en) begin
      ctr  <= nxt;
      wrap <= limit;
      ovf  <= ovf | limit;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three instances (mod 8 wrap, mod 6 wrap,
// mod 6 saturate) share stimulus and are checked against an integer model.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, clr;
  logic [2:0] load_val;

  logic [2:0] ctr_a, ctr_b, ctr_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       ovf_a, ovf_b, ovf_c;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr(clr), .ctr(ctr_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a));
  counter_updown_mod #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr(clr), .ctr(ctr_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b));
  counter_updown_mod #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr(clr), .ctr(ctr_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c));

  int checks   = 0;
  int failures = 0;

  int m_mod [3] = '{8, 6, 6};
  int m_sat [3] = '{0, 0, 1};
  int m_ctr [3] = '{0, 0, 0};
  int m_wrap[3] = '{0, 0, 0};
  int m_ovf [3] = '{0, 0, 0};
  bit m_valid   = 1'b0;

  typedef struct {
    logic r, cl, ld, e, ud;
    logic [2:0] lv;
    int c, w, o, t;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural next-state from the counting rules, in plain integers
  function automatic void model_step(input int mod, input int sat, input int c, input int o,
                                     input bit r, input bit cl, input bit ld, input bit e,
                                     input bit ud, input int lv,
                                     output int nc, output int nw, output int no);
    int n;
    nc = c; nw = 0; no = o;
    if (!r || cl) begin
      nc = 0; no = 0;
    end else if (ld) begin
      nc = (lv < mod) ? lv : mod - 1;
    end else if (e) begin
      n = ud ? c + 1 : c - 1;
      if (n >= mod) begin
        nw = 1; n = sat ? mod - 1 : 0;
      end else if (n < 0) begin
        nw = 1; n = sat ? 0 : mod - 1;
      end
      nc = n; no = o | nw;
    end
  endfunction

  task automatic sample(input int i, output int c, output int w, output int o, output int t);
    case (i)
      0:       begin c = int'(ctr_a); w = int'(wrap_a); o = int'(ovf_a); t = int'(tc_a); end
      1:       begin c = int'(ctr_b); w = int'(wrap_b); o = int'(ovf_b); t = int'(tc_b); end
      default: begin c = int'(ctr_c); w = int'(wrap_c); o = int'(ovf_c); t = int'(tc_c); end
    endcase
  endtask

  task automatic drive(input bit r, input bit cl, input bit ld, input bit e, input bit ud,
                       input int lv);
    rst = r; clr = cl; load = ld; en = e; up_dn = ud; load_val = 3'(lv);
  endtask

  // tc is "the next edge would be a limit event" ignoring reset/clear/load
  task automatic tick();
    int c, w, o, t, nc, nw, no;
    #1;
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        model_step(m_mod[i], m_sat[i], m_ctr[i], m_ovf[i], 1'b1, 1'b0, 1'b0, en, up_dn,
                   int'(load_val), nc, nw, no);
        sample(i, c, w, o, t);
        check($sformatf("model_tc[%0d]", i), t, nw);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      model_step(m_mod[i], m_sat[i], m_ctr[i], m_ovf[i], rst, clr, load, en, up_dn,
                 int'(load_val), nc, nw, no);
      m_ctr[i] = nc; m_wrap[i] = nw; m_ovf[i] = no;
    end
    if (!rst) m_valid = 1'b1;
    #1;
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        sample(i, c, w, o, t);
        check($sformatf("model_ctr[%0d]", i), c, m_ctr[i]);
        check($sformatf("model_wrap[%0d]", i), w, m_wrap[i]);
        check($sformatf("model_ovf[%0d]", i), o, m_ovf[i]);
      end
    end
  endtask

  function automatic vec_t mk(input bit r, input bit cl, input bit ld, input bit e,
                              input bit ud, input int lv, input int c, input int w,
                              input int o, input int t);
    vec_t v;
    v.r = r; v.cl = cl; v.ld = ld; v.e = e; v.ud = ud; v.lv = 3'(lv);
    v.c = c; v.w = w; v.o = o; v.t = t;
    return v;
  endfunction

  initial begin
    int exp_dn_c[4] = '{1, 0, 5, 4};
    int exp_dn_w[4] = '{0, 0, 1, 0};
    int exp_st_w[4] = '{0, 1, 1, 1};
    int exp_st_t[4] = '{0, 1, 1, 1};

    drive(1, 0, 0, 0, 1, 0);

    // Hand-computed vectors for the mod-8 wrap instance: {r,clr,ld,en,up,lv} -> ctr,wrap,ovf,tc
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) tbl.push_back(mk(1, 0, 0, 1, 1, 0, k, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 2, 0, 1, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 0, 0, 1, 0, 2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, 1, 3, 3, 0, 1, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 0, 0, 1, 0, 3, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 4, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 5, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 4, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 7, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 6, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 5, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 1, 7, 7, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 1, 1, 4, 4, 0, 1, 0));

    foreach (tbl[n]) begin
      drive(tbl[n].r, tbl[n].cl, tbl[n].ld, tbl[n].e, tbl[n].ud, int'(tbl[n].lv));
      #1;
      check($sformatf("tbl%0d_tc", n), int'(tc_a), tbl[n].t);
      tick();
      check($sformatf("tbl%0d_ctr", n), int'(ctr_a), tbl[n].c);
      check($sformatf("tbl%0d_wrap", n), int'(wrap_a), tbl[n].w);
      check($sformatf("tbl%0d_ovf", n), int'(ovf_a), tbl[n].o);
    end

    // Modulo-6 down count through zero on the wrap instance
    drive(1, 1, 0, 0, 1, 0); tick();
    drive(1, 0, 1, 0, 1, 2); tick();
    check("dn6_load", int'(ctr_b), 2);
    drive(1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("dn6_ctr%0d", k), int'(ctr_b), exp_dn_c[k]);
      check($sformatf("dn6_wrap%0d", k), int'(wrap_b), exp_dn_w[k]);
    end
    check("dn6_ovf", int'(ovf_b), 1);

    // Saturating up count holds at 5 with wrap high each held cycle
    drive(1, 1, 0, 0, 1, 0); tick();
    drive(1, 0, 1, 0, 1, 4); tick();
    check("sat_load", int'(ctr_c), 4);
    drive(1, 0, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("sat_tc%0d", k), int'(tc_c), exp_st_t[k]);
      tick();
      check($sformatf("sat_ctr%0d", k), int'(ctr_c), 5);
      check($sformatf("sat_wrap%0d", k), int'(wrap_c), exp_st_w[k]);
    end
    check("sat_ovf", int'(ovf_c), 1);

    // Load clamp with en high, then clear beating load
    drive(1, 0, 1, 1, 1, 7); tick();
    check("clamp_b", int'(ctr_b), 5);
    check("clamp_c", int'(ctr_c), 5);
    check("clamp_a", int'(ctr_a), 7);
    check("clamp_wrap_c", int'(wrap_c), 0);
    check("clamp_ovf_c", int'(ovf_c), 1);
    drive(1, 1, 1, 1, 1, 3); tick();
    check("clr_ctr_c", int'(ctr_c), 0);
    check("clr_ovf_c", int'(ovf_c), 0);

    // Randomised run against the model
    for (int k = 0; k < 2000; k++) begin
      drive($urandom_range(31) != 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
            $urandom_range(3) != 0, 1'($urandom_range(1)), int'($urandom_range(7)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
